// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared compare-mode encodings, stage-1 control payload and take selection
// Contents:
//   cmp_mode_e - compare mode select (EQZ, EQ, signed LT, unsigned LT)
//   s1_ctl_t   - per-entry control bits held in stage 1
//   cmp_take   - chooses the condition flag for a given mode
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQZ = 2'd0,
    CMP_EQ  = 2'd1,
    CMP_LT  = 2'd2,
    CMP_LTU = 2'd3
  } cmp_mode_e;

  // The wide difference, chunk vector and tag are sized by the instance
  // parameters, so they are kept beside this struct in the pipeline.
  typedef struct packed {
    cmp_mode_e mode;
    logic      a_msb;
    logic      b_msb;
  } s1_ctl_t;

  // Signed less-than is the sign of the difference corrected for overflow;
  // unsigned less-than is the borrow out of the WIDTH+1 subtraction.
  function automatic logic cmp_take(input cmp_mode_e mode, input logic zero,
                                    input logic neg, input logic ovf,
                                    input logic borrow);
    logic t;
    t = zero;
    case (mode)
      CMP_EQZ, CMP_EQ: t = zero;
      CMP_LT:          t = neg ^ ovf;
      CMP_LTU:         t = borrow;
      default:         t = zero;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/chunk_zero_reduce.sv
// rtl/chunk_zero_reduce.sv - per-chunk zero detection of a wide word
// Ports:
//   data in  WIDTH         word to examine
//   cz   out WIDTH/CHUNK   cz[i] = 1 when chunk i of data is all zeros
module chunk_zero_reduce #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic [WIDTH-1:0]       data,
  output logic [WIDTH/CHUNK-1:0] cz
);

  for (genvar i = 0; i < WIDTH / CHUNK; i++) begin : g_chunk
    assign cz[i] = ~|data[i*CHUNK +: CHUNK];
  end

endmodule

// File: rtl/cmp_flag_pipe.sv
// rtl/cmp_flag_pipe.sv - two-stage pipelined compare producing take/zero/neg/ovf flags
// Ports:
//   clock, reset (async active-high), flush (sync kill of in-flight entries)
//   in_valid/in_ready, a, b, mode, in_tag     request side
//   out_valid/out_ready, out_take, out_zero,
//   out_neg, out_ovf, out_tag                 result side
module cmp_flag_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_take,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NCH = WIDTH / CHUNK;

  cmp_mode_e        mode_in;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   d_in;
  logic [NCH-1:0]   cz_in;

  logic             s1_valid;
  s1_ctl_t          s1_ctl;
  logic [WIDTH:0]   s1_d;
  logic [NCH-1:0]   s1_cz;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic             s2_adv;
  logic             accept;

  logic             zero_n;
  logic             neg_n;
  logic             borrow_n;
  logic             ovf_n;
  logic             take_n;

  // Stage-1 datapath: one WIDTH+1 unsigned subtraction serves every mode;
  // forcing b to zero makes mode 0 a plain zero test of a.
  assign mode_in = cmp_mode_e'(mode);
  assign b_eff   = (mode_in == CMP_EQZ) ? '0 : b;
  assign d_in    = {1'b0, a} - {1'b0, b_eff};

  chunk_zero_reduce #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_chunk_zero (
    .data(d_in[WIDTH-1:0]),
    .cz  (cz_in)
  );

  // Stage-2 flag logic works only from registered stage-1 state.
  assign zero_n   = &s1_cz;
  assign neg_n    = s1_d[WIDTH-1];
  assign borrow_n = s1_d[WIDTH];
  assign ovf_n    = (s1_ctl.mode != CMP_EQZ) && (s1_ctl.a_msb != s1_ctl.b_msb)
                    && (neg_n != s1_ctl.a_msb);
  assign take_n   = cmp_take(s1_ctl.mode, zero_n, neg_n, ovf_n, borrow_n);

  // Handshake: in_ready never looks at in_valid, so there is no
  // combinational path from the request side to out_valid.
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !reset && (!s1_valid || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '{mode: CMP_EQZ, a_msb: 1'b0, b_msb: 1'b0};
      s1_d     <= '0;
      s1_cz    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      out_take <= 1'b0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
      out_tag  <= '0;
    end else begin
      if (accept) begin
        s1_ctl <= '{mode: mode_in, a_msb: a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
        s1_d   <= d_in;
        s1_cz  <= cz_in;
        s1_tag <= in_tag;
      end

      if (s2_adv && s1_valid) begin
        out_take <= take_n;
        out_zero <= zero_n;
        out_neg  <= neg_n;
        out_ovf  <= ovf_n;
        out_tag  <= s1_tag;
      end

      // Flush only kills valid bits; payload registers may keep stale data.
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          s2_valid <= s1_valid;
        end
        if (in_ready) begin
          s1_valid <= in_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_flag_pipe.sv
// tb/tb_cmp_flag_pipe.sv - self-checking bench for cmp_flag_pipe against a behavioural compare model
module tb_cmp_flag_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_take;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
  logic [4:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    logic [4:0] tag;
    logic       take;
    logic       zero;
    logic       neg;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t q[$];

  cmp_flag_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_take (out_take),
    .out_zero (out_zero),
    .out_neg  (out_neg),
    .out_ovf  (out_ovf),
    .out_tag  (out_tag)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: flags from integer arithmetic and language comparisons.
  function automatic exp_t ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic [1:0] rm, input logic [4:0] rt);
    exp_t e;
    logic [31:0] bb;
    logic [31:0] diff;
    longint sd;
    bb   = (rm == 2'd0) ? 32'd0 : rb;
    diff = ra - bb;
    sd   = longint'($signed(ra)) - longint'($signed(bb));
    e.tag  = rt;
    e.zero = (diff == 32'd0);
    e.neg  = diff[31];
    e.ovf  = (rm != 2'd0) && ((sd > 64'sd2147483647) || (sd < -64'sd2147483648));
    case (rm)
      2'd0:    e.take = (ra == 32'd0);
      2'd1:    e.take = (ra == rb);
      2'd2:    e.take = ($signed(ra) < $signed(rb));
      default: e.take = (ra < rb);
    endcase
    e.acc = 0;
    return e;
  endfunction

  logic [9:0] prev_out;
  bit         prev_stall = 1'b0;

  always @(posedge reset or negedge clock) begin
    exp_t e;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (prev_stall)
        check_eq("hold_stable", {out_valid, out_tag, out_take, out_zero, out_neg, out_ovf}, prev_out);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check_eq("out_tag", out_tag, e.tag);
          check_eq("out_take", out_take, e.take);
          check_eq("out_zero", out_zero, e.zero);
          check_eq("out_neg", out_neg, e.neg);
          check_eq("out_ovf", out_ovf, e.ovf);
          if (lat_chk) check_eq("latency", cyc - e.acc, 2);
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        e = ref_model(a, b, mode, in_tag);
        e.acc = cyc;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_out   = {out_valid, out_tag, out_take, out_zero, out_neg, out_ovf};
    end
  end

  task automatic drive(input logic [31:0] da, input logic [31:0] db,
                       input logic [1:0] dm, input logic [4:0] dt);
    in_valid = 1'b1;
    a = da;
    b = db;
    mode = dm;
    in_tag = dt;
  endtask

  task automatic send(input logic [31:0] da, input logic [31:0] db,
                      input logic [1:0] dm, input logic [4:0] dt);
    int n;
    drive(da, db, dm, dt);
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (n >= 50) check_eq("send_timeout", in_ready, 1'b1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_flags", {out_take, out_zero, out_neg, out_ovf}, 4'h0);
    check_eq("rst_tag", out_tag, 5'd0);
    reset = 1'b0;
    #1 check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;

    // Zero detect with latency check
    lat_chk = 1'b1;
    out_ready = 1'b1;
    send(32'h00000000, 32'hDEADBEEF, 2'd0, 5'd3);
    send(32'h00010000, 32'h00010000, 2'd0, 5'd4);
    // Signed vs unsigned, overflow, equality
    send(32'hFFFFFFFF, 32'h00000001, 2'd2, 5'd5);
    send(32'hFFFFFFFF, 32'h00000001, 2'd3, 5'd6);
    send(32'h80000000, 32'h00000001, 2'd2, 5'd7);
    send(32'h12345678, 32'h12345678, 2'd1, 5'd8);
    repeat (4) @(posedge clock);
    #1 lat_chk = 1'b0;

    // Back-pressure: two accepts fill the pipe, then release with no bubble
    out_ready = 1'b0;
    send(32'h00000001, 32'h00000002, 2'd3, 5'd10);
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 2'd2, 5'd11);
    drive(32'h00000005, 32'h00000005, 2'd1, 5'd12);
    repeat (3) begin
      @(negedge clock);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    check_eq("rel0_valid", out_valid, 1'b1);
    check_eq("rel0_ready", in_ready, 1'b1);
    @(posedge clock);
    #1 drive(32'h00000000, 32'h00000000, 2'd0, 5'd13);
    @(negedge clock);
    check_eq("rel1_valid", out_valid, 1'b1);
    check_eq("rel1_ready", in_ready, 1'b1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock) check_eq("rel2_valid", out_valid, 1'b1);
    @(negedge clock) check_eq("rel3_valid", out_valid, 1'b1);
    @(negedge clock) check_eq("rel_done", out_valid, 1'b0);
    @(posedge clock);
    #1;

    // Flush together with a new request
    send(32'h00000003, 32'h00000004, 2'd2, 5'd14);
    send(32'h00000009, 32'h00000001, 2'd3, 5'd15);
    drive(32'h00000000, 32'h00000000, 2'd0, 5'd16);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clock) check_eq("flush_empty", out_valid, 1'b0);
    @(posedge clock);
    #1;

    // Reset while full and stalled
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00000001, 2'd2, 5'd9);
    send(32'h80000000, 32'h00000001, 2'd2, 5'd17);
    drive(32'h00000001, 32'h00000001, 2'd1, 5'd18);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("rstmid_out_valid", out_valid, 1'b0);
    check_eq("rstmid_flags", {out_take, out_zero, out_neg, out_ovf}, 4'h0);
    check_eq("rstmid_tag", out_tag, 5'd0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1 check_eq("rstmid_in_ready", in_ready, 1'b1);
    @(negedge clock) check_eq("rstmid_empty", out_valid, 1'b0);

    // Randomised traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      mode      = 2'($urandom % 4);
      in_tag    = 5'($urandom);
      a         = $urandom;
      b         = $urandom;
      case ($urandom % 8)
        0: a = 32'd0;
        1: b = a;
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        4: a = {a[31:8], 8'h00} & 32'hFF00FF00;
        default: ;
      endcase
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain_empty", q.size(), 0);
    check_eq("drain_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
